// File: rtl/xpb_table_gen.sv
// XPB digit table generator: streams entry[k] = k*B mod N for k = 0 .. 2^DIGIT_W-1
// to a table RAM over a valid/ready write port, using one add and one conditional subtract per entry.
module xpb_table_gen #(
    parameter int DATA_W  = 1024,
    parameter int DIGIT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  modulus,
    input  logic [DATA_W-1:0]  base,
    output logic               busy,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [DIGIT_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, CHK, WR, ADD, RED, FIN} state_t;

    localparam logic [DIGIT_W-1:0] LAST_IDX = '1;

    state_t             state;
    logic [DATA_W-1:0]  n_reg;
    logic [DATA_W-1:0]  b_reg;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W:0]    sum;
    logic [DIGIT_W-1:0] idx;

    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  acc_next;

    // sum <= 2N-2, so the top bit of diff is a clean borrow: set exactly when sum < N.
    always_comb begin
        diff     = sum - {1'b0, n_reg};
        acc_next = diff[DATA_W] ? sum[DATA_W-1:0] : diff[DATA_W-1:0];
    end

    // NOTE: every register below is sequential state and uses non-blocking assignment,
    // so all of them update together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            sum      <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg <= modulus;
                        b_reg <= base;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (b_reg >= n_reg) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        wr_data  <= acc;
                        wr_addr  <= '0;
                        wr_valid <= 1'b1;
                        state    <= WR;
                    end
                end
                WR: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    sum   <= {1'b0, acc} + {1'b0, b_reg};
                    state <= RED;
                end
                RED: begin
                    acc      <= acc_next;
                    idx      <= idx + 1'b1;
                    wr_data  <= acc_next;
                    wr_addr  <= idx + 1'b1;
                    wr_valid <= 1'b1;
                    state    <= WR;
                end
                FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: every presented entry is compared against k*B mod N
// computed with plain wide arithmetic, plus cycle timing, error path and asynchronous reset.
module tb_xpb_table_gen;

    localparam int DATA_W  = 1024;
    localparam int DIGIT_W = 5;
    localparam int DEPTH   = 1 << DIGIT_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [DATA_W-1:0]  modulus;
    logic [DATA_W-1:0]  base;
    logic               busy;
    logic               wr_valid;
    logic               wr_ready;
    logic [DIGIT_W-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               done;
    logic               err;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] wdata [DEPTH];

    xpb_table_gen #(.DATA_W(DATA_W), .DIGIT_W(DIGIT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .modulus  (modulus),
        .base     (base),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_entry(input int k, input logic [DATA_W-1:0] n,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W+16:0] p;
        logic [DATA_W+16:0] nn;
        p  = (DATA_W+17)'(b) * (DATA_W+17)'(k);
        nn = (DATA_W+17)'(n);
        p  = p % nn;
        return p[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_wide();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One complete run from start to done. rand_ready: 50% wr_ready; inject: pulse a bogus
    // start mid-run that must be ignored.
    task automatic run(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] b,
                       input bit rand_ready, input bit inject, input bit exp_err);
        int  rel;
        int  nxt;
        int  last_acc;
        bit  got_done;
        rel = 0; nxt = 0; last_acc = -1; got_done = 0;
        @(negedge clk);
        modulus = n; base = b; start = 1'b1; wr_ready = 1'b1;
        @(posedge clk);
        while (rel < 2000) begin
            #1;
            start    = 1'b0;
            wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            rel++;
            check("busy_in_run", busy, 1);
            if (!done) check("err_without_done", err, 0);
            if (wr_valid) begin
                check("wr_addr", wr_addr, nxt[DIGIT_W-1:0]);
                if (nxt < DEPTH) check("wr_data", wr_data, ref_entry(nxt, n, b));
                if (wr_ready) begin
                    if (!rand_ready) check("wr_cycle", rel, 2 + 3 * nxt);
                    if (nxt < DEPTH) wdata[nxt] = wr_data;
                    nxt++;
                    last_acc = rel;
                end
            end
            if (done) begin
                got_done = 1;
                break;
            end
            if (inject && rel == 20) begin
                start   = 1'b1;
                modulus = rand_wide();
                base    = rand_wide();
            end
            @(posedge clk);
        end
        check("done_seen", got_done, 1);
        check("err_flag", err, exp_err);
        check("write_count", nxt, exp_err ? 0 : DEPTH);
        if (exp_err)         check("done_cycle", rel, 2);
        else if (rand_ready) check("done_after_last", rel, last_acc + 1);
        else                 check("done_cycle", rel, 96);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("valid_after", wr_valid, 0);
    endtask

    task automatic reset_mid_run(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] b);
        bit hit;
        hit = 0;
        @(negedge clk);
        modulus = n; base = b; start = 1'b1; wr_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 200 && !hit; c++) begin
            #1;
            start    = 1'b0;
            wr_ready = 1'b1;
            @(negedge clk);
            if (wr_valid && wr_addr == 5'd10) begin
                wr_ready = 1'b0;
                hit = 1;
            end else begin
                @(posedge clk);
            end
        end
        check("reach_entry10", hit, 1);
        check("stall_data10", wr_data, ref_entry(10, n, b));
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", wr_valid, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] n;
        logic [DATA_W-1:0] b;
        rst = 1'b1; start = 1'b0; modulus = '0; base = '0; wr_ready = 1'b0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_valid", wr_valid, 0);
        check("reset_addr", wr_addr, 0);
        check("reset_data", wr_data, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Small modulus, ready held high: exact timing and hand-computed entries.
        run(DATA_W'(16'hFFF1), DATA_W'(16'h8000), 0, 0, 0);
        check("t1_e1", wdata[1], DATA_W'(16'h8000));
        check("t1_e2", wdata[2], DATA_W'(16'h000F));
        check("t1_e3", wdata[3], DATA_W'(16'h800F));
        check("t1_e4", wdata[4], DATA_W'(16'h001E));

        // B = N-1: entry[k] = N-k.
        run(DATA_W'(16'hFFF1), DATA_W'(16'hFFF0), 0, 0, 0);
        check("t2_e0", wdata[0], DATA_W'(0));
        check("t2_e1", wdata[1], DATA_W'(16'hFFF0));
        check("t2_e31", wdata[31], DATA_W'(16'hFFD2));

        // Full-width random moduli, alternating steady and random wr_ready.
        for (int s = 0; s < 20; s++) begin
            n = rand_wide();
            n[DATA_W-1] = 1'b1;
            n[0] = 1'b1;
            b = rand_wide();
            if (b >= n) b = b - n;
            run(n, b, s[0], 0, 0);
            check("rand_e1_is_b", wdata[1], b);
        end

        // Random stalls with a start pulse during busy that must be ignored.
        run(DATA_W'(16'hFFF1), DATA_W'(16'h1234), 1, 1, 0);

        // Error path: B = N and B = N+1.
        run(DATA_W'(16'hFFF1), DATA_W'(16'hFFF1), 0, 0, 1);
        run(DATA_W'(16'hFFF1), DATA_W'(17'h0FFF2), 1, 0, 1);

        // Asynchronous reset during a stall, then a clean rerun from entry 0.
        n = rand_wide();
        n[DATA_W-1] = 1'b1;
        n[0] = 1'b1;
        b = rand_wide() >> 1;
        reset_mid_run(n, b);
        run(n, b, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
